// File: rtl/ltssm_rx_sequencer.sv
// ltssm_rx_sequencer: drives the RX ordered-set checker through the Detect,
// Polling and Configuration substates, counting checker countup pulses per
// substate and returning to detectQuiet on timeout or loss of start.
`timescale 1ns/1ps
module ltssm_rx_sequencer #(
  parameter int unsigned DEVICETYPE     = 0,
  parameter int unsigned POLL_ACT_CNT   = 8,
  parameter int unsigned POLL_CFG_CNT   = 8,
  parameter int unsigned CFG_CNT        = 2,
  parameter int unsigned CPL_CNT        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rx_detected,
  input  logic       countup,
  input  logic       resetcounter,
  input  logic [7:0] rateid,
  input  logic       upconfigure_capability,
  output logic [3:0] substate,
  output logic       checker_rst_n,
  output logic       link_up,
  output logic       timeout_err,
  output logic [7:0] link_rate,
  output logic       upcfg
);

  localparam int unsigned CW = 5;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [3:0] {
    DETECT_QUIET          = 4'd0,
    DETECT_ACTIVE         = 4'd1,
    POLLING_ACTIVE        = 4'd2,
    POLLING_CONFIGURATION = 4'd3,
    CFG_LINKWIDTH_START   = 4'd4,
    CFG_LINKWIDTH_ACCEPT  = 4'd5,
    CFG_LANENUM_WAIT      = 4'd6,
    CFG_LANENUM_ACCEPT    = 4'd7,
    CFG_COMPLETE          = 4'd8,
    CFG_IDLE              = 4'd9
  } state_t;

  state_t         state;
  state_t         state_nxt;
  state_t         count_exit;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_thr;
  logic [TW-1:0]  timer;
  logic           timeout_hit;
  logic           timed;

  assign substate = state;

  // Per-substate count threshold and the substate reached when it is met
  always_comb begin
    cnt_thr    = CW'(CFG_CNT);
    count_exit = DETECT_QUIET;
    timed      = 1'b1;
    case (state)
      POLLING_ACTIVE: begin
        cnt_thr    = CW'(POLL_ACT_CNT);
        count_exit = POLLING_CONFIGURATION;
      end
      POLLING_CONFIGURATION: begin
        cnt_thr    = CW'(POLL_CFG_CNT);
        count_exit = CFG_LINKWIDTH_START;
      end
      CFG_LINKWIDTH_START:
        count_exit = (DEVICETYPE == 1) ? CFG_LINKWIDTH_ACCEPT : CFG_LANENUM_WAIT;
      CFG_LINKWIDTH_ACCEPT: count_exit = CFG_LANENUM_WAIT;
      CFG_LANENUM_WAIT:     count_exit = CFG_LANENUM_ACCEPT;
      CFG_LANENUM_ACCEPT:   count_exit = CFG_COMPLETE;
      CFG_COMPLETE: begin
        cnt_thr    = CW'(CPL_CNT);
        count_exit = CFG_IDLE;
      end
      default: timed = 1'b0;
    endcase
  end

  // Next substate; timeout wins over loss of start and over a count exit
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      DETECT_QUIET:
        if (start) state_nxt = DETECT_ACTIVE;
      DETECT_ACTIVE:
        if (!start)          state_nxt = DETECT_QUIET;
        else if (rx_detected) state_nxt = POLLING_ACTIVE;
      CFG_IDLE:
        if (!start) state_nxt = DETECT_QUIET;
      POLLING_ACTIVE, POLLING_CONFIGURATION, CFG_LINKWIDTH_START,
      CFG_LINKWIDTH_ACCEPT, CFG_LANENUM_WAIT, CFG_LANENUM_ACCEPT,
      CFG_COMPLETE: begin
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt   = DETECT_QUIET;
          timeout_hit = 1'b1;
        end else if (!start) begin
          state_nxt = DETECT_QUIET;
        end else if (cnt == cnt_thr) begin
          state_nxt = count_exit;
        end
      end
      default: state_nxt = DETECT_QUIET;
    endcase
  end

  // State, checker reset, counters and captured link parameters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= DETECT_QUIET;
      checker_rst_n <= 1'b0;
      cnt           <= '0;
      timer         <= '0;
      link_up       <= 1'b0;
      timeout_err   <= 1'b0;
      link_rate     <= '0;
      upcfg         <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_err <= timeout_hit;
      link_up     <= (state_nxt == CFG_IDLE);
      if (state_nxt != state) begin
        checker_rst_n <= 1'b0;
        cnt           <= '0;
        timer         <= '0;
      end else begin
        checker_rst_n <= (state != DETECT_QUIET);
        if (!checker_rst_n || !resetcounter) begin
          cnt <= '0;
        end else if (countup && (cnt != {CW{1'b1}})) begin
          cnt <= cnt + CW'(1);
        end
        timer <= timed ? timer + TW'(1) : '0;
      end
      if ((state == CFG_COMPLETE) && (state_nxt == CFG_IDLE)) begin
        link_rate <= rateid;
        upcfg     <= upconfigure_capability;
      end
    end
  end

endmodule

// File: tb/tb_ltssm_rx_sequencer.sv
// Directed bench for ltssm_rx_sequencer: upstream and downstream instances
// share stimulus; sel chooses which one the checks observe.
`timescale 1ns/1ps
module tb_ltssm_rx_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       rx_detected;
  logic       countup;
  logic       resetcounter;
  logic [7:0] rateid;
  logic       upconfigure_capability;
  logic       sel;

  logic [3:0] up_substate, dn_substate;
  logic       up_rst_n, dn_rst_n;
  logic       up_link_up, dn_link_up;
  logic       up_tmo, dn_tmo;
  logic [7:0] up_rate, dn_rate;
  logic       up_upcfg, dn_upcfg;

  logic [3:0] o_sub;
  logic       o_rst_n, o_link_up, o_tmo, o_upcfg;
  logic [7:0] o_rate;

  int n_checks = 0;
  int n_fail   = 0;

  ltssm_rx_sequencer #(.DEVICETYPE(1)) u_up (
    .clk(clk), .reset(reset), .start(start), .rx_detected(rx_detected),
    .countup(countup), .resetcounter(resetcounter), .rateid(rateid),
    .upconfigure_capability(upconfigure_capability),
    .substate(up_substate), .checker_rst_n(up_rst_n), .link_up(up_link_up),
    .timeout_err(up_tmo), .link_rate(up_rate), .upcfg(up_upcfg)
  );

  ltssm_rx_sequencer #(.DEVICETYPE(0)) u_dn (
    .clk(clk), .reset(reset), .start(start), .rx_detected(rx_detected),
    .countup(countup), .resetcounter(resetcounter), .rateid(rateid),
    .upconfigure_capability(upconfigure_capability),
    .substate(dn_substate), .checker_rst_n(dn_rst_n), .link_up(dn_link_up),
    .timeout_err(dn_tmo), .link_rate(dn_rate), .upcfg(dn_upcfg)
  );

  assign o_sub     = sel ? dn_substate : up_substate;
  assign o_rst_n   = sel ? dn_rst_n    : up_rst_n;
  assign o_link_up = sel ? dn_link_up  : up_link_up;
  assign o_tmo     = sel ? dn_tmo      : up_tmo;
  assign o_rate    = sel ? dn_rate     : up_rate;
  assign o_upcfg   = sel ? dn_upcfg    : up_upcfg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the observed substate to change; check the new value, the dwell
  // and the one-cycle checker reset at entry.
  task automatic walk_step(input string tag, input int exp_state, input int exp_dwell);
    int n;
    logic [3:0] prev;
    n    = 0;
    prev = o_sub;
    while (o_sub == prev && n < 2000) begin
      tick();
      n++;
      if (o_sub == prev && n == 1 && prev != 4'd0)
        check({tag, "_rel"}, 32'(o_rst_n), 32'd1);
    end
    check({tag, "_state"}, 32'(o_sub), 32'(exp_state));
    check({tag, "_dwell"}, 32'(n), 32'(exp_dwell));
    check({tag, "_rstlow"}, 32'(o_rst_n), 32'd0);
  endtask

  int up_seq[9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int up_dwell[9] = '{1, 1, 10, 10, 4, 4, 4, 4, 10};
  int dn_seq[8]   = '{1, 2, 3, 4, 6, 7, 8, 9};
  int dn_dwell[8] = '{1, 1, 10, 10, 4, 4, 4, 10};

  initial begin
    sel = 1'b0;
    reset = 1'b0;
    start = 1'b0;
    rx_detected = 1'b0;
    countup = 1'b0;
    resetcounter = 1'b1;
    rateid = 8'h05;
    upconfigure_capability = 1'b0;
    #1;
    check("rst_sub", 32'(o_sub), 32'd0);
    check("rst_crst", 32'(o_rst_n), 32'd0);
    check("rst_lu", 32'(o_link_up), 32'd0);
    check("rst_tmo", 32'(o_tmo), 32'd0);
    check("rst_rate", 32'(o_rate), 32'd0);
    check("rst_upcfg", 32'(o_upcfg), 32'd0);
    #21 reset = 1'b1;
    tick();
    tick();
    check("idle_sub", 32'(o_sub), 32'd0);
    check("idle_crst", 32'(o_rst_n), 32'd0);

    // Upstream bring-up
    start = 1'b1; rx_detected = 1'b1; countup = 1'b1;
    for (int i = 0; i < 9; i++) walk_step("up", up_seq[i], up_dwell[i]);
    check("up_lu", 32'(o_link_up), 32'd1);
    check("up_rate", 32'(o_rate), 32'h05);
    check("up_upcfg", 32'(o_upcfg), 32'd0);
    check("up_tmo", 32'(o_tmo), 32'd0);

    // Downstream skip of configurationLinkWidthAccept
    start = 1'b0;
    tick();
    check("up_drop", 32'(up_substate), 32'd0);
    check("up_drop_lu", 32'(up_link_up), 32'd0);
    check("dn_drop", 32'(dn_substate), 32'd0);
    tick();
    sel = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 8; i++) walk_step("dn", dn_seq[i], dn_dwell[i]);
    check("dn_lu", 32'(o_link_up), 32'd1);

    // Timeout in pollingConfiguration
    sel = 1'b0;
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    walk_step("tmo_a", 1, 1);
    walk_step("tmo_b", 2, 1);
    walk_step("tmo_c", 3, 10);
    countup = 1'b0;
    walk_step("tmo", 0, 1024);
    check("tmo_err", 32'(o_tmo), 32'd1);
    check("tmo_rate", 32'(o_rate), 32'h05);
    start = 1'b0;
    tick();
    check("tmo_pulse", 32'(o_tmo), 32'd0);
    check("tmo_sub", 32'(o_sub), 32'd0);

    // Counter clear inside pollingActive
    start = 1'b1;
    walk_step("clr_a", 1, 1);
    walk_step("clr_b", 2, 1);
    tick();
    countup = 1'b1;
    repeat (5) tick();
    resetcounter = 1'b0;
    tick();
    resetcounter = 1'b1;
    repeat (7) tick();
    check("clr_7", 32'(o_sub), 32'd2);
    tick();
    check("clr_8", 32'(o_sub), 32'd2);
    tick();
    check("clr_exit", 32'(o_sub), 32'd3);
    check("clr_crst", 32'(o_rst_n), 32'd0);

    // Capture at configurationIdle entry
    rateid = 8'h1F;
    upconfigure_capability = 1'b1;
    walk_step("cap_4", 4, 10);
    walk_step("cap_5", 5, 4);
    walk_step("cap_6", 6, 4);
    walk_step("cap_7", 7, 4);
    walk_step("cap_8", 8, 4);
    walk_step("cap_9", 9, 10);
    check("cap_rate", 32'(o_rate), 32'h1F);
    check("cap_upcfg", 32'(o_upcfg), 32'd1);
    rateid = 8'hAA;
    upconfigure_capability = 1'b0;
    tick();
    check("cap_hold_rate", 32'(o_rate), 32'h1F);
    check("cap_hold_upcfg", 32'(o_upcfg), 32'd1);
    start = 1'b0;
    tick();
    check("cap_down_sub", 32'(o_sub), 32'd0);
    check("cap_down_lu", 32'(o_link_up), 32'd0);
    check("cap_down_rate", 32'(o_rate), 32'h1F);
    check("cap_down_upcfg", 32'(o_upcfg), 32'd1);

    // Asynchronous reset in lanenumAccept with cnt = 1
    tick();
    start = 1'b1;
    for (int i = 0; i < 7; i++) walk_step("ar", up_seq[i], up_dwell[i]);
    tick();
    tick();
    check("ar_pre", 32'(o_sub), 32'd7);
    #2 reset = 1'b0;
    #1;
    check("ar_sub", 32'(o_sub), 32'd0);
    check("ar_crst", 32'(o_rst_n), 32'd0);
    check("ar_lu", 32'(o_link_up), 32'd0);
    check("ar_rate", 32'(o_rate), 32'd0);
    check("ar_upcfg", 32'(o_upcfg), 32'd0);
    start = 1'b0;
    #3 reset = 1'b1;
    tick();
    check("ar_idle", 32'(o_sub), 32'd0);
    start = 1'b1;
    walk_step("ar_re1", 1, 1);
    walk_step("ar_re2", 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ltssm_rx_sequencer.md
Name: ltssm_rx_sequencer

Overview:
- Controls the RX-side ordered-set checker by driving its substate input and its active-low reset.
- Counts the checker's countup pulses while resetcounter is high, and advances through the Detect, Polling and Configuration substates when each per-substate count threshold is met.
- Applies a per-substate timeout that returns the link to detectQuiet.
- On entry to configurationIdle, captures the data rate ID and upconfigure capability from the checker.

Parameters:
- DEVICETYPE, 0, 0 = downstream port (configurationLinkWidthAccept is skipped), 1 = upstream port.
- POLL_ACT_CNT, 8, countup pulses needed to leave pollingActive.
- POLL_CFG_CNT, 8, countup pulses needed to leave pollingConfiguration.
- CFG_CNT, 2, countup pulses needed to leave substates 4 through 7.
- CPL_CNT, 8, countup pulses needed to leave configurationComplete.
- TIMEOUT_CYCLES, 1024, cycles allowed in substates 2 through 8 before the timeout fires.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  link-up request; level-sensitive.
- rx_detected  in  1  receiver detected.
- countup  in  1  from checker.
- resetcounter  in  1  from checker; 0 clears the count.
- rateid  in  8  from checker.
- upconfigure_capability  in  1  from checker.
- substate  out  4  substate drive to checker; encoding 0 through 9 per the LTSSM substate list.
- checker_rst_n  out  1  active-low reset to checker.
- link_up  out  1  high while in configurationIdle.
- timeout_err  out  1  one-cycle pulse on timeout.
- link_rate  out  8  captured rate ID.
- upcfg  out  1  captured upconfigure capability.

Behaviour:
- Reset values (reset low):
  - substate = 0 (detectQuiet); checker_rst_n = 0.
  - cnt = 0; timer = 0.
  - link_up, timeout_err, link_rate, upcfg = 0.
- All outputs are registered.
- State register equals the substate output. Transitions (evaluated each clock edge):
  - 0 → 1 when start = 1.
  - 1 → 2 when rx_detected = 1; 1 → 0 when start = 0.
  - 2 → 3 when cnt == POLL_ACT_CNT.
  - 3 → 4 when cnt == POLL_CFG_CNT.
  - 4 → 5 (DEVICETYPE = 1) or 4 → 6 (DEVICETYPE = 0) when cnt == CFG_CNT.
  - 5 → 6, 6 → 7 and 7 → 8 when cnt == CFG_CNT.
  - 8 → 9 when cnt == CPL_CNT.
  - 9 → 0 when start = 0.
  - Any state 2–8 → 0 when timer == TIMEOUT_CYCLES - 1; timeout_err = 1 for that one cycle. Timeout has priority over a simultaneous count exit.
  - start = 0 in any state 2–8 → 0, with no timeout_err.
- Substate change:
  - On every change (including to 0), checker_rst_n is 0 for exactly the first cycle in the new substate, then 1.
  - In detectQuiet, checker_rst_n stays 0.
  - cnt and timer clear at the same edge.
- Count:
  - If checker_rst_n = 0 or resetcounter = 0: cnt ← 0.
  - Else if countup = 1: cnt ← cnt + 1, saturating at 31 (5-bit).
  - Exit compares the registered cnt, so the transition occurs one cycle after the threshold-reaching countup is registered.
- Timer:
  - Increments every cycle in substates 2–8; held at 0 elsewhere.
  - Width is $clog2(TIMEOUT_CYCLES) + 1.
- Capture:
  - On the 8 → 9 edge, link_rate ← rateid and upcfg ← upconfigure_capability.
  - Both hold until reset or the next capture; they are not cleared on 9 → 0.
- link_up = 1 exactly while substate == 9.
- Asynchronous reset mid-operation returns every output to its reset value immediately.
- countup while resetcounter = 0 is ignored.

Test Plan:
1. Normal upstream bring-up (DEVICETYPE = 1, defaults). Stimulus: start = 1, rx_detected = 1, then continuous countup = 1 with resetcounter = 1 after each checker release. Required: substate sequence 0, 1, 2, 3, 4, 5, 6, 7, 8, 9. checker_rst_n pulses low for one cycle at each change. In state 2, the 2 → 3 transition occurs on the cycle after cnt reaches 8. link_up = 1 in 9.
2. Downstream skip (DEVICETYPE = 0), same stimulus as scenario 1. Required: substate goes 4 → 6; 5 never appears.
3. Timeout: hold substate 3 with countup = 0. Required: after 1024 cycles in 3, substate = 0 and timeout_err = 1 for exactly 1 cycle. link_rate is unchanged.
4. Counter clear: in state 2, apply 5 countups, drop resetcounter for 1 cycle, then apply 7 countups. Required: no exit; the 8th countup after the clear causes the exit.
5. Capture: hold rateid = 8'h1F and upconfigure_capability = 1 at the 8 → 9 edge, then change them. Required: link_rate = 8'h1F and upcfg = 1 hold; they persist after start = 0 returns the link to 0.
6. Async reset in state 7 with cnt = 1. Required: substate = 0, checker_rst_n = 0 and link_up = 0 immediately; after reset release, the bench restarts cleanly from 0.
